// File: rtl/trap_ctrl.sv
// M-mode trap sequencer: arbitrates exceptions, mret and interrupts, writes the
// trap CSRs, then redirects and flushes the pipeline to mtvec or mepc.
module trap_ctrl #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            trap_req_i,
  input  logic [3:0]      trap_cause_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic [XLEN-1:0] trap_tval_i,
  input  logic            mret_i,
  input  logic            commit_v_i,
  input  logic [XLEN-1:0] commit_pc_i,
  input  logic            irq_msip_i,
  input  logic            irq_mtip_i,
  input  logic            irq_meip_i,
  input  logic [XLEN-1:0] mstatus_i,
  input  logic [XLEN-1:0] mie_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,
  output logic [3:0]      csr_we_o,
  output logic [XLEN-1:0] mepc_o,
  output logic [XLEN-1:0] mcause_o,
  output logic [XLEN-1:0] mtval_o,
  output logic [XLEN-1:0] mstatus_o,
  output logic [XLEN-1:0] mip_o,
  output logic            trap_ack_o,
  output logic            busy_o,
  output logic            redirect_v_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            flush_o,
  input  logic            fetch_ok_i
);

  typedef enum logic [1:0] {IDLE, WRITE, REDIRECT, WAIT} state_t;

  state_t          state, state_nxt;
  logic [2:0]      irq_s1, irq_s2;  // {meip, mtip, msip}
  logic            take_exc, take_mret, take_irq;
  logic [3:0]      irq_code;
  logic [XLEN-1:0] base, trap_mstatus, mret_mstatus;
  logic            lat_irq, lat_mret;
  logic [XLEN-1:0] lat_epc, lat_cause, lat_tval, lat_mstatus, lat_target;
  logic            unused_bits;

  assign unused_bits = ^{mie_i[XLEN-1:12], mie_i[10:8], mie_i[6:4], mie_i[2:0], mepc_i[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_s1 <= '0;
      irq_s2 <= '0;
    end else begin
      irq_s1 <= {irq_meip_i, irq_mtip_i, irq_msip_i};
      irq_s2 <= irq_s1;
    end
  end

  always_comb begin
    mip_o     = '0;
    mip_o[3]  = irq_s2[0];
    mip_o[7]  = irq_s2[1];
    mip_o[11] = irq_s2[2];
  end

  // Arbitration: exception > mret > MEI > MSI > MTI; interrupts only at a commit boundary
  always_comb begin
    take_exc  = trap_req_i;
    take_mret = !trap_req_i && mret_i;
    take_irq  = 1'b0;
    irq_code  = 4'd0;
    if (!trap_req_i && !mret_i && commit_v_i && mstatus_i[3]) begin
      if (mie_i[11] && mip_o[11]) begin
        take_irq = 1'b1;
        irq_code = 4'd11;
      end else if (mie_i[3] && mip_o[3]) begin
        take_irq = 1'b1;
        irq_code = 4'd3;
      end else if (mie_i[7] && mip_o[7]) begin
        take_irq = 1'b1;
        irq_code = 4'd7;
      end
    end
  end

  always_comb begin
    base             = {mtvec_i[XLEN-1:2], 2'b00};
    trap_mstatus     = mstatus_i;
    trap_mstatus[7]  = mstatus_i[3];
    trap_mstatus[3]  = 1'b0;
    trap_mstatus[12:11] = 2'b11;
    mret_mstatus     = mstatus_i;
    mret_mstatus[3]  = mstatus_i[7];
    mret_mstatus[7]  = 1'b1;
    mret_mstatus[12:11] = 2'b11;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      lat_irq     <= 1'b0;
      lat_mret    <= 1'b0;
      lat_epc     <= '0;
      lat_cause   <= '0;
      lat_tval    <= '0;
      lat_mstatus <= '0;
      lat_target  <= '0;
    end else begin
      state <= state_nxt;
      // Everything the later states need is frozen here, so inputs may change while busy
      if (state == IDLE && (take_exc || take_mret || take_irq)) begin
        lat_irq  <= take_irq;
        lat_mret <= take_mret;
        if (take_exc) begin
          lat_epc     <= trap_pc_i;
          lat_cause   <= {{(XLEN-4){1'b0}}, trap_cause_i};
          lat_tval    <= trap_tval_i;
          lat_mstatus <= trap_mstatus;
          lat_target  <= base;
        end else if (take_mret) begin
          lat_epc     <= '0;
          lat_cause   <= '0;
          lat_tval    <= '0;
          lat_mstatus <= mret_mstatus;
          lat_target  <= {mepc_i[XLEN-1:2], 2'b00};
        end else begin
          lat_epc     <= commit_pc_i;
          lat_cause   <= {1'b1, {(XLEN-5){1'b0}}, irq_code};
          lat_tval    <= '0;
          lat_mstatus <= trap_mstatus;
          lat_target  <= (mtvec_i[1:0] == 2'b01) ? base + {{(XLEN-6){1'b0}}, irq_code, 2'b00} : base;
        end
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    csr_we_o      = '0;
    mepc_o        = '0;
    mcause_o      = '0;
    mtval_o       = '0;
    mstatus_o     = '0;
    trap_ack_o    = 1'b0;
    busy_o        = (state != IDLE);
    redirect_v_o  = 1'b0;
    redirect_pc_o = '0;
    flush_o       = 1'b0;
    case (state)
      IDLE: begin
        if (take_exc || take_mret || take_irq) state_nxt = WRITE;
      end
      WRITE: begin
        state_nxt  = REDIRECT;
        trap_ack_o = !lat_irq;
        csr_we_o   = lat_mret ? 4'b1000 : 4'b1111;
        mepc_o     = lat_epc;
        mcause_o   = lat_cause;
        mtval_o    = lat_tval;
        mstatus_o  = lat_mstatus;
      end
      REDIRECT: begin
        redirect_v_o  = 1'b1;
        flush_o       = 1'b1;
        redirect_pc_o = lat_target;
        state_nxt     = fetch_ok_i ? IDLE : WAIT;
      end
      WAIT: begin
        redirect_pc_o = lat_target;
        if (fetch_ok_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
